// File: rtl/sprite_if.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_if
//  Description : Control/pixel bus between a sprite sweep controller and the
//                sprite_datapath. The controller (master) drives the sweep
//                enable, operation and motion strobes; the datapath (slave)
//                returns the pixel coordinate, colour, write strobe, end-of-
//                sweep flag and the screen-edge indicator.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    datapath_en  master->slave  advance one pixel of the current sweep
//    op[1:0]      master->slave  op[0]=0 draw, op[0]=1 erase; op[1] ignored
//    load_coord   master->slave  one-cycle strobe: step sprite position
//    move_en      master->slave  qualifies load_coord
//    x[7:0]       slave->master  pixel x coordinate
//    y[6:0]       slave->master  pixel y coordinate
//    colour[2:0]  slave->master  pixel colour
//    plot         slave->master  frame-buffer write strobe
//    done         slave->master  last pixel of a sweep presented this cycle
//    touch_edge   slave->master  sprite sits on a screen boundary
// ============================================================================
interface sprite_if;
    logic       datapath_en;
    logic [1:0] op;
    logic       load_coord;
    logic       move_en;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       done;
    logic       touch_edge;

    modport master (
        output datapath_en,
        output op,
        output load_coord,
        output move_en,
        input  x,
        input  y,
        input  colour,
        input  plot,
        input  done,
        input  touch_edge
    );

    modport slave (
        input  datapath_en,
        input  op,
        input  load_coord,
        input  move_en,
        output x,
        output y,
        output colour,
        output plot,
        output done,
        output touch_edge
    );
endinterface
`default_nettype wire

// File: rtl/sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_datapath
//  Description : Raster sweep datapath for a rectangular sprite. A col/row
//                pixel counter walks the SPR_W x SPR_H sprite one pixel per
//                enabled cycle; the pixel coordinate is the sprite base
//                position plus the counter. The base position steps one unit
//                per qualified load_coord strobe in the current direction of
//                each axis and is confined to the visible screen.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SPR_W   sprite width in pixels               (default 25)
//    SPR_H   sprite height in pixels              (default 10)
//    SCR_W   screen width in pixels               (default 160)
//    SCR_H   screen height in pixels              (default 120)
//    COLOUR  draw colour                          (default 3'b111)
//  Ports
//    clk     sole clock, rising edge
//    reset   synchronous active-high reset
//    bus     sprite_if.slave (see sprite_if for the signal list)
//  Build option
//    BOUNCE_EN  defined   : a step past a limit reverses that axis and moves
//                           one unit back the other way
//               undefined : directions are fixed after reset and a step past
//                           a limit saturates at the limit
// ============================================================================
module sprite_datapath #(
    parameter int         SPR_W  = 25,
    parameter int         SPR_H  = 10,
    parameter int         SCR_W  = 160,
    parameter int         SCR_H  = 120,
    parameter logic [2:0] COLOUR = 3'b111
) (
    input  wire logic clk,
    input  wire logic reset,
    sprite_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_COL_W = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int c_ROW_W = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(SPR_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(SPR_H - 1);

    // Largest legal base so that the whole sprite stays on screen.
    localparam logic [7:0] c_MAX_X = 8'(SCR_W - SPR_W);
    localparam logic [6:0] c_MAX_Y = 7'(SCR_H - SPR_H);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [7:0]         r_base_x;
    logic [6:0]         r_base_y;
    logic               r_dir_x;
    logic               r_dir_y;
    logic               r_touch;

    // ------------------------------------------------------------------------
    // Combinational next-state / decode
    // ------------------------------------------------------------------------
    logic               w_col_last;
    logic               w_row_last;
    logic               w_step;
    logic [c_COL_W-1:0] w_col_nxt;
    logic [c_ROW_W-1:0] w_row_nxt;
    logic [7:0]         w_base_x_nxt;
    logic [6:0]         w_base_y_nxt;
    logic               w_dir_x_nxt;
    logic               w_dir_y_nxt;
    logic               w_on_edge;

    assign w_col_last = (r_col == c_COL_LAST);
    assign w_row_last = (r_row == c_ROW_LAST);
    assign w_step     = bus.load_coord & bus.move_en;

    // Pixel counter: col is the fast index, row advances on col wrap and both
    // return to the origin after the final pixel. Frozen while not enabled.
    always_comb begin
        w_col_nxt = r_col;
        w_row_nxt = r_row;
        if (bus.datapath_en) begin
            if (w_col_last) begin
                w_col_nxt = '0;
                if (w_row_last) begin
                    w_row_nxt = '0;
                end else begin
                    w_row_nxt = r_row + c_ROW_W'(1);
                end
            end else begin
                w_col_nxt = r_col + c_COL_W'(1);
            end
        end
    end

    // Horizontal position step.
    always_comb begin
        w_base_x_nxt = r_base_x;
        w_dir_x_nxt  = r_dir_x;
        if (w_step) begin
`ifdef BOUNCE_EN
            if (r_dir_x) begin
                if (r_base_x >= c_MAX_X) begin
                    // Already at the right limit: reverse and move back.
                    w_base_x_nxt = r_base_x - 8'd1;
                    w_dir_x_nxt  = 1'b0;
                end else begin
                    w_base_x_nxt = r_base_x + 8'd1;
                end
            end else begin
                if (r_base_x == 8'd0) begin
                    w_base_x_nxt = 8'd1;
                    w_dir_x_nxt  = 1'b1;
                end else begin
                    w_base_x_nxt = r_base_x - 8'd1;
                end
            end
`else
            // Saturate at whichever limit lies in the travel direction.
            if (r_dir_x) begin
                if (r_base_x < c_MAX_X) begin
                    w_base_x_nxt = r_base_x + 8'd1;
                end
            end else begin
                if (r_base_x != 8'd0) begin
                    w_base_x_nxt = r_base_x - 8'd1;
                end
            end
`endif
        end
    end

    // Vertical position step; same rules as the horizontal axis.
    always_comb begin
        w_base_y_nxt = r_base_y;
        w_dir_y_nxt  = r_dir_y;
        if (w_step) begin
`ifdef BOUNCE_EN
            if (r_dir_y) begin
                if (r_base_y >= c_MAX_Y) begin
                    w_base_y_nxt = r_base_y - 7'd1;
                    w_dir_y_nxt  = 1'b0;
                end else begin
                    w_base_y_nxt = r_base_y + 7'd1;
                end
            end else begin
                if (r_base_y == 7'd0) begin
                    w_base_y_nxt = 7'd1;
                    w_dir_y_nxt  = 1'b1;
                end else begin
                    w_base_y_nxt = r_base_y - 7'd1;
                end
            end
`else
            if (r_dir_y) begin
                if (r_base_y < c_MAX_Y) begin
                    w_base_y_nxt = r_base_y + 7'd1;
                end
            end else begin
                if (r_base_y != 7'd0) begin
                    w_base_y_nxt = r_base_y - 7'd1;
                end
            end
`endif
        end
    end

    // Edge detect on the current base; registering it makes touch_edge trail
    // a position change by one cycle.
    assign w_on_edge = (r_base_x == 8'd0) || (r_base_x == c_MAX_X) ||
                       (r_base_y == 7'd0) || (r_base_y == c_MAX_Y);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col    <= '0;
            r_row    <= '0;
            r_base_x <= 8'd0;
            r_base_y <= 7'd0;
            r_dir_x  <= 1'b1;
            r_dir_y  <= 1'b1;
            r_touch  <= 1'b1;   // the origin is itself a boundary
        end else begin
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_base_x <= w_base_x_nxt;
            r_base_y <= w_base_y_nxt;
            r_dir_x  <= w_dir_x_nxt;
            r_dir_y  <= w_dir_y_nxt;
            r_touch  <= w_on_edge;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: coordinate and colour are combinational from the current
    // counter/base (pre-update when a step coincides with a pixel).
    // ------------------------------------------------------------------------
    assign bus.x          = r_base_x + 8'(r_col);
    assign bus.y          = r_base_y + 7'(r_row);
    assign bus.colour     = bus.op[0] ? 3'b000 : COLOUR;
    assign bus.plot       = bus.datapath_en;
    assign bus.done       = bus.datapath_en & w_col_last & w_row_last;
    assign bus.touch_edge = r_touch;

endmodule
`default_nettype wire

// File: tb/tb_sprite_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sprite_datapath
//  Description : Self-checking bench for sprite_datapath. Directed stimulus
//                pushes the expected pixel of every enabled cycle into a
//                scoreboard queue; a monitor on the falling edge pops and
//                compares whenever the DUT raises plot. Idle cycles check the
//                held coordinate and the registered edge flag directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sprite_datapath;

    localparam int c_SPR_W = 25;
    localparam int c_SPR_H = 10;
    localparam int c_MAX_X = 135;
    localparam int c_MAX_Y = 110;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sprite_if bus ();

    sprite_datapath #(
        .SPR_W  (c_SPR_W),
        .SPR_H  (c_SPR_H),
        .SCR_W  (160),
        .SCR_H  (120),
        .COLOUR (3'b111)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
        logic       done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state of the sprite
    int   m_col, m_row, m_bx, m_by;
    bit   m_dx, m_dy, m_touch;
    bit   m_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic move_axis(inout int b, inout bit d, input int mx);
`ifdef BOUNCE_EN
        if (d) begin
            if (b >= mx) begin b = b - 1; d = 1'b0; end
            else b = b + 1;
        end else begin
            if (b == 0) begin b = 1; d = 1'b1; end
            else b = b - 1;
        end
`else
        if (d && b < mx) b = b + 1;
        else if (!d && b > 0) b = b - 1;
`endif
    endtask

    // One clock cycle of stimulus: drive after the edge, record expectation,
    // then advance the reference to the state after the next edge.
    task automatic cycle(input bit rst, input bit en, input bit [1:0] o,
                         input bit lc, input bit me);
        exp_t e;
        @(posedge clk);
        #1;
        if (m_valid) chk("touch_edge", bus.touch_edge, m_touch);
        reset           = rst;
        bus.datapath_en = en;
        bus.op          = o;
        bus.load_coord  = lc;
        bus.move_en     = me;
        if (m_valid) begin
            if (en) begin
                e.x      = 8'(m_bx + m_col);
                e.y      = 7'(m_by + m_row);
                e.colour = o[0] ? 3'b000 : 3'b111;
                e.done   = (m_col == c_SPR_W - 1) && (m_row == c_SPR_H - 1);
                sb.push_back(e);
            end else begin
                #1;
                chk("idle_x", bus.x, m_bx + m_col);
                chk("idle_y", bus.y, m_by + m_row);
                chk("idle_done", bus.done, 0);
                chk("idle_plot", bus.plot, 0);
            end
        end
        if (rst) begin
            m_col = 0; m_row = 0; m_bx = 0; m_by = 0;
            m_dx = 1'b1; m_dy = 1'b1; m_touch = 1'b1;
            m_valid = 1'b1;
        end else begin
            m_touch = (m_bx == 0) || (m_bx == c_MAX_X) || (m_by == 0) || (m_by == c_MAX_Y);
            if (en) begin
                if (m_col == c_SPR_W - 1) begin
                    m_col = 0;
                    m_row = (m_row == c_SPR_H - 1) ? 0 : m_row + 1;
                end else begin
                    m_col = m_col + 1;
                end
            end
            if (lc && me) begin
                move_axis(m_bx, m_dx, c_MAX_X);
                move_axis(m_by, m_dy, c_MAX_Y);
            end
        end
    endtask

    // Monitor: every plotted pixel must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.plot === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_plot actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("pix_x", bus.x, e.x);
                chk("pix_y", bus.y, e.y);
                chk("pix_colour", bus.colour, e.colour);
                chk("pix_done", bus.done, e.done);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.datapath_en = 1'b0;
        bus.op          = 2'b00;
        bus.load_coord  = 1'b0;
        bus.move_en     = 1'b0;

        // Reset state
        cycle(1, 0, 2'b00, 0, 0);
        cycle(1, 0, 2'b00, 0, 0);
        cycle(0, 0, 2'b00, 0, 0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_touch", bus.touch_edge, 1);

        // Full draw sweep, then counter back at origin
        repeat (250) cycle(0, 1, 2'b00, 0, 0);
        cycle(0, 0, 2'b00, 0, 0);
        chk("sweep_end_x", bus.x, 0);
        chk("sweep_end_y", bus.y, 0);

        // Sweep with a pause after 30 pixels: hold at (5,1)
        repeat (30) cycle(0, 1, 2'b00, 0, 0);
        repeat (5) begin
            cycle(0, 0, 2'b00, 0, 0);
            chk("gap_x", bus.x, 5);
            chk("gap_y", bus.y, 1);
        end
        repeat (220) cycle(0, 1, 2'b00, 0, 0);

        // Erase sweep
        repeat (250) cycle(0, 1, 2'b01, 0, 0);

        // op changing every pixel; op[1] alone must still draw
        for (int i = 0; i < 250; i++)
            cycle(0, 1, (i % 3 == 0) ? 2'b01 : ((i % 3 == 1) ? 2'b10 : 2'b11), 0, 0);
        cycle(0, 0, 2'b00, 0, 0);

        // Motion: 135 strobes, one more, then up to 200 total
        repeat (135) cycle(0, 0, 2'b00, 1, 1);
        cycle(0, 0, 2'b00, 0, 0);
        chk("mv135_x", bus.x, 135);
`ifdef BOUNCE_EN
        chk("mv135_y", bus.y, 85);
`else
        chk("mv135_y", bus.y, 110);
`endif
        chk("mv135_touch", bus.touch_edge, 1);
        cycle(0, 0, 2'b00, 1, 1);
        cycle(0, 0, 2'b00, 0, 0);
`ifdef BOUNCE_EN
        chk("mv136_x", bus.x, 134);
`else
        chk("mv136_x", bus.x, 135);
`endif
        repeat (64) cycle(0, 0, 2'b00, 1, 1);
        cycle(0, 0, 2'b00, 0, 0);
        cycle(0, 0, 2'b00, 0, 0);
`ifdef BOUNCE_EN
        chk("mv200_x", bus.x, 70);
        chk("mv200_y", bus.y, 20);
        chk("mv200_touch", bus.touch_edge, 0);
`else
        chk("mv200_x", bus.x, 135);
        chk("mv200_y", bus.y, 110);
        chk("mv200_touch", bus.touch_edge, 1);
`endif

        // Strobes without move_en do nothing
        repeat (10) cycle(0, 0, 2'b00, 1, 0);
`ifdef BOUNCE_EN
        chk("gated_x", bus.x, 70);
        chk("gated_y", bus.y, 20);
`else
        chk("gated_x", bus.x, 135);
        chk("gated_y", bus.y, 110);
`endif

        // Abort a sweep at pixel (10,4) with reset
        repeat (110) cycle(0, 1, 2'b00, 0, 0);
        cycle(1, 0, 2'b00, 0, 0);
        cycle(0, 0, 2'b00, 0, 0);
        chk("abort_x", bus.x, 0);
        chk("abort_y", bus.y, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_touch", bus.touch_edge, 1);

        // Step and pixel together: coordinate uses pre-step base
        repeat (3) cycle(0, 1, 2'b00, 1, 1);
        cycle(0, 0, 2'b00, 0, 0);
        chk("combo_x", bus.x, 6);
        chk("combo_y", bus.y, 3);

        repeat (3) cycle(0, 0, 2'b00, 0, 0);
        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop guard in case the clocked stimulus ever stalls
    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sprite_datapath.md
SPRITE_DATAPATH -- requirements
Module: sprite_datapath

Interface
REQ-001 SHALL provide parameter SPR_W, default 25, meaning sprite width in pixels.
REQ-002 SHALL provide parameter SPR_H, default 10, meaning sprite height in pixels.
REQ-003 SHALL provide parameter SCR_W, default 160, meaning screen width in pixels.
REQ-004 SHALL provide parameter SCR_H, default 120, meaning screen height in pixels.
REQ-005 SHALL provide parameter COLOUR, default 3'b111, meaning sprite draw colour.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 datapath_en  input  1  advance one pixel of the current sweep this cycle.
REQ-009 op  input  2  op[0]=0: draw in COLOUR; op[0]=1: erase (colour 0); op[1] ignored.
REQ-010 load_coord  input  1  one-cycle strobe: step sprite position by one unit.
REQ-011 move_en  input  1  gates load_coord; with move_en low, load_coord is ignored.
REQ-012 x  output  8  pixel x = base_x + col.
REQ-013 y  output  7  pixel y = base_y + row.
REQ-014 colour  output  3  COLOUR when op[0]=0, else 3'b000.
REQ-015 plot  output  1  equals datapath_en; write strobe to the frame buffer.
REQ-016 done  output  1  high in the cycle the last pixel of a sweep is presented.
REQ-017 touch_edge  output  1  registered; high while sprite sits on any screen boundary.

Function
REQ-018 Pixel counter SHALL hold col (0..SPR_W-1) and row (0..SPR_H-1); x, y, colour combinational from counter, base and op (zero latency).
REQ-019 Each cycle datapath_en=1: col increments; at col=SPR_W-1, col wraps to 0 and row increments; at col=SPR_W-1 and row=SPR_H-1 both wrap to 0.
REQ-020 done SHALL be 1 exactly when datapath_en=1, col=SPR_W-1, row=SPR_H-1 (250th enabled cycle by default); 0 otherwise.
REQ-021 datapath_en low mid-sweep SHALL freeze col/row; sweep resumes at the same pixel.
REQ-022 Position registers base_x (8 b), base_y (7 b), range 0..SCR_W-SPR_W (135) and 0..SCR_H-SPR_H (110); direction flags dir_x, dir_y (1 = increasing).
REQ-023 On load_coord=1 and move_en=1, base_x and base_y SHALL each step by one in their direction, resolved per REQ-030/031.
REQ-024 load_coord and datapath_en together: both updates occur; x/y that cycle use pre-update base.
REQ-025 touch_edge SHALL update one cycle after any base change: 1 when base_x in {0,135} or base_y in {0,110}.
REQ-026 op changes mid-sweep SHALL affect colour immediately; counter unaffected.

Reset
REQ-027 reset=1 SHALL force col=0, row=0, base_x=0, base_y=0, dir_x=1, dir_y=1, touch_edge=1 (origin is an edge) on the next edge, overriding all inputs.
REQ-028 After reset: x=0, y=0, done=0; plot and colour follow inputs.
REQ-029 reset mid-sweep SHALL abandon the sweep; next sweep starts at pixel (0,0) with no done for the aborted one.

Configuration
REQ-030 Macro BOUNCE_EN defined: a step beyond a limit SHALL flip that axis's direction and move one unit the opposite way (base_x=135, dir_x=1 -> base_x=134, dir_x=0).
REQ-031 BOUNCE_EN undefined: directions never change after reset; a step beyond a limit SHALL saturate at that limit; touch_edge remains high while saturated.

Verification
REQ-032 Reset, datapath_en=1 for 250 cycles, op=0 -> (x,y) sweeps (0,0)..(24,9) raster order, colour=7, done high only in cycle 250, counter back at (0,0).
REQ-033 datapath_en high 30 cycles, low 5, high 220 -> x=5,y=1 held during gap; done on the 250th enabled cycle only.
REQ-034 op=2'b01 full sweep -> colour=0 every cycle, plot=1 throughout, done once.
REQ-035 BOUNCE_EN: 135 load_coord strobes from reset -> base_x=135, touch_edge=1; one more -> base_x=134, dir_x=0; base_y saturates/bounces at 110 per REQ-030.
REQ-036 Without BOUNCE_EN: 200 strobes -> base_x=135, base_y=110, touch_edge=1; strobes with move_en=0 -> no change.
REQ-037 reset asserted at pixel (10,4) -> next cycle x=0, y=0, base (0,0), touch_edge=1, done=0.
